// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Multi-cycle control stage for a combinational WxW array multiplier.
//   A start request seen in IDLE latches the operands onto mult_a/mult_b.
//   The multiplier is then given LAT settle cycles. After that, the 2W-bit
//   product is captured into the HI/LO result registers and done pulses for
//   one cycle.
//
//   Optional feature macro: MULT_SIGNED_EN
//     defined   : is_signed selects two's-complement operands. The multiplier
//                 receives operand magnitudes, and the captured product is
//                 negated when the operand signs differ.
//     undefined : every operation is unsigned; is_signed is accepted but ignored.
//
//   Parameters
//     W    operand width (product is 2W)
//     LAT  settle cycles for the multiplier, 1..15
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      operation request, sampled only in IDLE
//     is_signed  signed operands (MULT_SIGNED_EN builds only)
//     op_a/op_b  multiplicand / multiplier
//     busy       operation in flight (registered)
//     done       one-cycle pulse when hi/lo have just been updated (registered)
//     hi/lo      upper / lower product halves (registered, held until next capture)
//     mult_a/b   registered operands driven to the array multiplier
//     mult_y     unsigned 2W-bit product returned by the array multiplier
module mult_seq_ctrl #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic [W-1:0]   mult_a,
  output logic [W-1:0]   mult_b,
  input  logic [2*W-1:0] mult_y
);

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  if (LAT < 1 || LAT > 15) begin : g_lat_check
    $error("mult_seq_ctrl: LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_mult_a;
  logic [W-1:0]   r_mult_b;
  logic           w_accept;
  logic [W-1:0]   w_opnd_a;
  logic [W-1:0]   w_opnd_b;
  logic [2*W-1:0] w_result;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef MULT_SIGNED_EN
  logic r_neg;
  logic w_neg;

  // Magnitudes are taken in W bits; the most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  assign w_opnd_a = (is_signed && op_a[W-1]) ? (~op_a + W'(1)) : op_a;
  assign w_opnd_b = (is_signed && op_b[W-1]) ? (~op_b + W'(1)) : op_b;
  assign w_neg    = is_signed && (op_a[W-1] ^ op_b[W-1]);
  assign w_result = r_neg ? (~mult_y + (2*W)'(1)) : mult_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_neg;
    end
  end
`else
  // is_signed stays on the port list so both builds share one interface.
  logic w_unused_sign;
  assign w_unused_sign = is_signed;
  assign w_opnd_a      = op_a;
  assign w_opnd_b      = op_b;
  assign w_result      = mult_y;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_WAIT;
      S_WAIT:    if (r_cnt == 4'd0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Settle counter: loaded with LAT-1 so WAIT lasts exactly LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // busy is registered from the next state so it appears with WAIT and
  // drops with the return to IDLE; done follows CAPTURE by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_CAPTURE);
    end
  end

  // Operand and result registers. Operands change only on an accepted
  // start, which keeps the multicycle path into CAPTURE stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_mult_a <= w_opnd_a;
        r_mult_b <= w_opnd_b;
      end
      if (r_state == S_CAPTURE) begin
        {r_hi, r_lo} <= w_result;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign mult_a = r_mult_a;
  assign mult_b = r_mult_b;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  mult_a;
  logic [W-1:0]  mult_b;
  logic [63:0]   mult_y;

  int n_total = 0;
  int n_pass  = 0;

  mult_seq_ctrl #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y)
  );

  // Combinational array multiplier standing in for the real instance.
  assign mult_y = {32'd0, mult_a} * {32'd0, mult_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] f_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa, xb;
`ifdef MULT_SIGNED_EN
    xa = s ? {{32{a[31]}}, a} : {32'd0, a};
    xb = s ? {{32{b[31]}}, b} : {32'd0, b};
`else
    xa = {32'd0, a};
    xb = {32'd0, b};
`endif
    return xa * xb;
  endfunction

  function automatic logic [31:0] f_mag(input logic [31:0] a, input logic s);
`ifdef MULT_SIGNED_EN
    if (s && a[31]) return 32'd0 - a;
`endif
    return a;
  endfunction

  logic        m_idle;
  int          m_rem;
  logic [63:0] m_prod;
  logic        e_busy, e_done;
  logic [31:0] e_hi, e_lo, e_ma, e_mb;

  // Each accepted request finishes LAT+1 edges later; its result and done
  // become visible right after that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_rem <= 0; m_prod <= '0;
      e_busy <= 1'b0; e_done <= 1'b0;
      e_hi <= '0; e_lo <= '0; e_ma <= '0; e_mb <= '0;
    end else begin
      e_done <= 1'b0;
      if (m_idle) begin
        if (start) begin
          m_prod <= f_prod(op_a, op_b, is_signed);
          e_ma   <= f_mag(op_a, is_signed);
          e_mb   <= f_mag(op_b, is_signed);
          m_rem  <= LAT + 1;
          m_idle <= 1'b0;
          e_busy <= 1'b1;
        end
      end else begin
        if (m_rem == 1) begin
          e_hi   <= m_prod[63:32];
          e_lo   <= m_prod[31:0];
          e_done <= 1'b1;
          e_busy <= 1'b0;
          m_idle <= 1'b1;
        end
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",   64'(busy),   64'(e_busy));
    chk("done",   64'(done),   64'(e_done));
    chk("hi",     64'(hi),     64'(e_hi));
    chk("lo",     64'(lo),     64'(e_lo));
    chk("mult_a", 64'(mult_a), 64'(e_ma));
    chk("mult_b", 64'(mult_b), 64'(e_mb));
  end

  // ---------------- stimulus ----------------
  // Issues one request and returns the number of edges from the sampling
  // edge to the edge at which done is seen (-1 if it never arrives).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
    @(posedge clk); #2;
    start = 1'b1; op_a = a; op_b = b; is_signed = s;
    @(posedge clk); #2;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    logic seen;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_hi",     64'(hi),     64'd0);
    chk("rst_lo",     64'(lo),     64'd0);
    chk("rst_mult_a", 64'(mult_a), 64'd0);
    rst_n = 1'b1;

    run_op(32'd3, 32'd5, 1'b0, lat);
    chk("basic_lat", 64'(lat), 64'(LAT + 2));
    chk("basic_hi",  64'(hi), 64'h0);
    chk("basic_lo",  64'(lo), 64'hF);
    chk("model_basic_lo", 64'(e_lo), 64'hF);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    chk("umax_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("umax_lo", 64'(lo), 64'h1);
    chk("model_umax_hi", 64'(e_hi), 64'hFFFF_FFFE);

`ifdef MULT_SIGNED_EN
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, lat);
    chk("s_m3x5_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("s_m3x5_lo", 64'(lo), 64'hFFFF_FFF1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    chk("s_min_hi", 64'(hi), 64'h4000_0000);
    chk("s_min_lo", 64'(lo), 64'h0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
    chk("s_m1_hi", 64'(hi), 64'h0);
    chk("s_m1_lo", 64'(lo), 64'h1);
    chk("model_s_m1_lo", 64'(e_lo), 64'h1);
`else
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
    chk("nosign_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("nosign_lo", 64'(lo), 64'h1);
    chk("model_nosign_hi", 64'(e_hi), 64'hFFFF_FFFE);
`endif

    // Handshake: 7x6 accepted, 2x2 during busy ignored, 9x9 on done cycle.
    @(posedge clk); #2;
    start = 1'b1; op_a = 32'd7; op_b = 32'd6; is_signed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      start = 1'b1; op_a = 32'd2; op_b = 32'd2;
    end
    @(posedge clk); #2;
    chk("hs_done1", 64'(done), 64'd1);
    chk("hs_lo1",   64'(lo),   64'd42);
    chk("hs_ma1",   64'(mult_a), 64'd7);
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #2;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("hs_lat2", 64'(lat), 64'(LAT + 2));
    chk("hs_lo2",  64'(lo),  64'd81);

    // Reset in the middle of an operation.
    @(posedge clk); #2;
    start = 1'b1; op_a = 32'd10; op_b = 32'd10;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rmid_nodone", 64'(seen), 64'd0);
    chk("rmid_hi",     64'(hi),   64'd0);
    chk("rmid_lo",     64'(lo),   64'd0);
    chk("rmid_busy",   64'(busy), 64'd0);
    chk("rmid_ma",     64'(mult_a), 64'd0);

    // Random traffic: requests arrive at any time, including while busy
    // and on done cycles; the per-cycle compare tracks the model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      start     = ($urandom_range(0, 2) == 0);
      op_a      = pick();
      op_b      = pick();
      is_signed = $urandom_range(0, 1) == 1;
    end
    @(posedge clk); #2;
    start = 1'b0;
    repeat (LAT + 6) @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Multi-cycle control stage wrapped around the ALU's combinational 32×32 array multiplier. Registers operands on a start handshake and drives them to the multiplier. Allows a fixed number of settle cycles, then captures the 2W-bit product into HI/LO result registers. It sits between the ALU decode/operand path (upstream) and the multiplier instance (downstream), and hands the registered product to register writeback.

## Interface

**Parameters**
- `W`, 32: operand width; product is 2W.
- `LAT`, 2: settle cycles granted to the combinational multiplier; legal range 1..15.

**Ports**
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `is_signed` input 1: operands are two's complement; honoured only with `MULT_SIGNED_EN`.
- `op_a` input W: multiplicand.
- `op_b` input W: multiplier.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: single-cycle pulse when `hi`/`lo` are updated.
- `hi` output W: upper product half, registered.
- `lo` output W: lower product half, registered.
- `mult_a` output W: registered operand to the array multiplier.
- `mult_b` output W: registered operand to the array multiplier.
- `mult_y` input 2W: unsigned product returned from the array multiplier.

## Operation

- **Reset (async, `rst_n`=0):**
  - State is IDLE.
  - `busy`=0, `done`=0.
  - `hi`=0, `lo`=0, `mult_a`=0, `mult_b`=0.
  - Settle counter is 0 and the negate flag is 0.
- **FSM states:** IDLE, WAIT, CAPTURE.
- **IDLE:**
  - On `start`=1: latch operands into `mult_a`/`mult_b`, load counter with LAT-1, go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:**
  - `busy`=1.
  - Counter decrements each cycle.
  - At counter 0, go to CAPTURE.
  - `mult_a`/`mult_b` are held constant.
- **CAPTURE:**
  - `busy`=1.
  - `{hi,lo}` ← `mult_y`, or its 2W-bit two's-complement negation if the negate flag is set.
  - Go to IDLE.
- **done:** registered; asserted for exactly the one cycle following CAPTURE, while state is IDLE.
- **start while busy:** ignored, not queued; operands are not re-latched.
- **start in the cycle done=1:** accepted, since the state is IDLE.
- **hi/lo retention:** hold their value until the next CAPTURE; never cleared except by reset.
- **Unsigned path:** `mult_a`=`op_a`, `mult_b`=`op_b`, negate flag = 0.
- **Signed path (macro only, `is_signed`=1):**
  - `mult_a`=|`op_a|`, `mult_b`=|`op_b|`, computed in W bits.
  - The magnitude of -2^(W-1) is 2^(W-1) unsigned, with no overflow.
  - Negate flag = `op_a[W-1]` XOR `op_b[W-1]`, latched with the operands.
- **Reset mid-operation:** the in-flight result is discarded, no `done` is produced, and all outputs return to their reset values.

## Timing

- **Cycle numbering:** cycle 0 is the rising edge where `start` is sampled in IDLE.
- **busy:** high for cycles 1..LAT+1.
- **done:** high in cycle LAT+2.
- **hi/lo:** valid from cycle LAT+2.
- **Total latency:** LAT+2 cycles from start to done.
- **Throughput:** back-to-back start on the done cycle gives one result every LAT+2 cycles.
- **Multicycle path:** `mult_y` is sampled only in CAPTURE, which is LAT+1 cycles after the operands change; the path from `mult_a`/`mult_b` to capture is constrained as multicycle LAT+1.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- **Macro:** `MULT_SIGNED_EN`.
- **Defined:**
  - The `is_signed` input is honoured.
  - Operand magnitude logic, the negate flag and the 2W-bit output negator are compiled in.
- **Undefined:**
  - `is_signed` is ignored; the port remains for interface stability.
  - All operations are unsigned.
  - No magnitude or negate logic is present.

## Test plan

- **Unsigned basic:**
  - Stimulus: LAT=2, `op_a`=3, `op_b`=5, start pulse in cycle 0.
  - Response: `busy` high in cycles 1–3; `done` high in cycle 4 only; `hi`=0x00000000, `lo`=0x0000000F.
- **Unsigned max:**
  - Stimulus: `op_a`=`op_b`=0xFFFFFFFF, `is_signed`=0.
  - Response: `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed, with `MULT_SIGNED_EN`:**
  - -3 × 5: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - 0x80000000 × 0x80000000: `hi`=0x40000000, `lo`=0.
  - -1 × -1: `hi`=0, `lo`=1.
- **Signed, without `MULT_SIGNED_EN`:**
  - Stimulus: `is_signed`=1, -1 × -1.
  - Response: unsigned result, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Handshake:**
  - Stimulus: start 7×6, re-assert start with 2×2 in cycles 1–3, then start 9×9 in the done cycle.
  - Response: first result is `lo`=42; the 2×2 request is ignored; second result is `lo`=81, with its done LAT+2 cycles after the first done.
- **Reset mid-operation:**
  - Stimulus: start 10×10, drop `rst_n` in cycle 2, release it, then idle for 6 cycles.
  - Response: no `done` pulse; `hi`=`lo`=0, `busy`=0.
